// File: rtl/pipe_ifq_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ifq_if
// Brief    : IF->ID queue handshake bundle. Beats are {pc[31:0], inst[31:0]}.
//            slave  = queue side, master = IFU/decoder side.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_ifq_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [63:0]   ifToId_i;     // {pc, inst} from IFU
  logic          if_valid_i;
  logic          id_ready_o;
  logic [63:0]   idInst_o;     // {pc, inst} to decoder
  logic          id_valid_o;
  logic          dec_ready_i;
  logic [CW-1:0] count_o;

  modport slave (
    input  ifToId_i, if_valid_i, dec_ready_i,
    output id_ready_o, idInst_o, id_valid_o, count_o
  );

  modport master (
    output ifToId_i, if_valid_i, dec_ready_i,
    input  id_ready_o, idInst_o, id_valid_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ifq.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ifq
// Brief    : In-order instruction queue between fetch and decode. DEPTH
//            entries, one-cycle flush, no bypass, ready derived from state.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ifq #(
  parameter int DEPTH = 4
) (
  input  wire logic       clk_i,
  input  wire logic       rst_ni,
  input  wire logic       flush_i,
  pipe_ifq_if.slave       q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;

  logic ready;
  logic valid;
  logic push;
  logic pop;

  // Handshake terms; ready only looks at registered occupancy so a full
  // queue refuses a beat even when the decoder pops in the same cycle.
  always_comb begin
    ready = (cnt != CW'(DEPTH));
    valid = (cnt != '0) & ~flush_i;
    push  = q.if_valid_i & ready & ~flush_i;
    pop   = valid & q.dec_ready_i;
  end

  assign q.id_ready_o = ready;
  assign q.id_valid_o = valid;
  assign q.idInst_o   = mem[rptr];
  assign q.count_o    = cnt;

  // Pointer and occupancy update; flush wins over any handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage write; cleared on reset so the head output is never X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= q.ifToId_i;
    end
  end
endmodule
`default_nettype wire
